// File: rtl/full_adder.sv
// Ripple-carry adder built from a chain of one-bit full-adder cells, with a
// combinational result and a one-stage registered copy carrying signed overflow.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_r,
  output logic             cout_r,
  output logic             ovf_r,
  output logic             out_valid
);
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic [WIDTH:0] c;
  res_t           res_d, res_q;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c[i]),
        .s  (sum[i]),
        .co (c[i+1])
      );
    end
  endgenerate

  assign cout = c[WIDTH];

  // Carry into vs. out of the MSB; for WIDTH=1 the carry into the MSB is cin.
  assign res_d = '{sum: sum, cout: c[WIDTH], ovf: c[WIDTH] ^ c[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res_d;
    end
  end

  assign sum_r  = res_q.sum;
  assign cout_r = res_q.cout;
  assign ovf_r  = res_q.ovf;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH 1, 8 and 16 against an arithmetic reference model.

module tb_full_adder;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0;

  always #5 if (clk_en) clk = ~clk;

  logic        a1 = 0, b1 = 0, cin1 = 0, sum1, cout1, sum_r1, cout_r1, ovf_r1, ov1;
  logic [7:0]  a8 = 0, b8 = 0, sum8, sum_r8;
  logic        cin8 = 0, cout8, cout_r8, ovf_r8, ov8;
  logic [15:0] a16 = 0, b16 = 0, sum16, sum_r16;
  logic        cin16 = 0, cout16, cout_r16, ovf_r16, ov16;

  full_adder #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(in_valid),
    .sum(sum1), .cout(cout1), .sum_r(sum_r1), .cout_r(cout_r1), .ovf_r(ovf_r1),
    .out_valid(ov1));
  full_adder #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(in_valid),
    .sum(sum8), .cout(cout8), .sum_r(sum_r8), .cout_r(cout_r8), .ovf_r(ovf_r8),
    .out_valid(ov8));
  full_adder #(.WIDTH(16)) d16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .in_valid(in_valid),
    .sum(sum16), .cout(cout16), .sum_r(sum_r16), .cout_r(cout_r16), .ovf_r(ovf_r16),
    .out_valid(ov16));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
  function automatic void model(input int w, input longint a, input longint b, input bit ci,
                                output longint s, output bit co, output bit ov);
    longint t, sa, sb, sr, half;
    t    = a + b + longint'(ci);
    s    = t & ((64'sd1 <<< w) - 1);
    co   = ((t >>> w) & 1) != 0;
    half = 64'sd1 <<< (w - 1);
    sa   = (a >= half) ? a - (64'sd1 <<< w) : a;
    sb   = (b >= half) ? b - (64'sd1 <<< w) : b;
    sr   = sa + sb + longint'(ci);
    ov   = (sr > half - 1) || (sr < -half);
  endfunction

  task automatic test_comb_sweep();
    logic [7:0] tbl_s = 8'b1001_0110;
    logic [7:0] tbl_c = 8'b1110_1000;
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin1} = v;
      #10;
      n_cmp++;
      if ({sum1, cout1} !== {tbl_s[i], tbl_c[i]}) begin
        n_bad++;
        $display("FAIL comb_sweep abc=%b got sum/cout=%b/%b want %b/%b",
                 v, sum1, cout1, tbl_s[i], tbl_c[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    a8 = 8'hAA; b8 = 8'h11; a16 = 16'h1234; b16 = 16'h4321; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({sum_r1, cout_r1, ovf_r1, ov1, sum_r8, cout_r8, ovf_r8, ov8,
         sum_r16, cout_r16, ovf_r16, ov16} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got w1=%b%b%b%b w8=%h%b%b%b w16=%h%b%b%b want all zero",
               sum_r1, cout_r1, ovf_r1, ov1, sum_r8, cout_r8, ovf_r8, ov8,
               sum_r16, cout_r16, ovf_r16, ov16);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_w1();
    @(posedge clk); #1;
    a1 = 1; b1 = 1; cin1 = 1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({sum_r1, cout_r1, ovf_r1, ov1} !== 4'b1101) begin
      n_bad++;
      $display("FAIL w1_capture got sum_r/cout_r/ovf_r/vld=%b%b%b%b want 1101",
               sum_r1, cout_r1, ovf_r1, ov1);
    end
    a1 = 0; b1 = 0; cin1 = 0;
    @(posedge clk); #1;
    n_cmp++;
    if ({sum_r1, cout_r1, ov1} !== 3'b110) begin
      n_bad++;
      $display("FAIL w1_hold got sum_r/cout_r/vld=%b%b%b want 110", sum_r1, cout_r1, ov1);
    end
  endtask

  task automatic test_w8_boundaries();
    logic [7:0] va[3] = '{8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb[3] = '{8'h01, 8'h01, 8'h80};
    logic       vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es[3] = '{8'h00, 8'h80, 8'h01};
    logic       ec[3] = '{1'b1, 1'b0, 1'b1};
    logic       eo[3] = '{1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a8 = va[k]; b8 = vb[k]; cin8 = vc[k]; in_valid = 1'b1;
      #1;
      n_cmp++;
      if ({sum8, cout8} !== {es[k], ec[k]}) begin
        n_bad++;
        $display("FAIL w8_comb[%0d] got %h/%b want %h/%b", k, sum8, cout8, es[k], ec[k]);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({sum_r8, cout_r8, ovf_r8, ov8} !== {es[k], ec[k], eo[k], 1'b1}) begin
        n_bad++;
        $display("FAIL w8_reg[%0d] got %h/%b/%b/%b want %h/%b/%b/1", k,
                 sum_r8, cout_r8, ovf_r8, ov8, es[k], ec[k], eo[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint es[4];
    bit     ec[4], eo[4];
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k > 0) begin
        n_cmp++;
        if ({sum_r8, cout_r8, ovf_r8, ov8} !== {es[k-1][7:0], ec[k-1], eo[k-1], 1'b1}) begin
          n_bad++;
          $display("FAIL b2b[%0d] got %h/%b/%b/%b want %h/%b/%b/1", k - 1,
                   sum_r8, cout_r8, ovf_r8, ov8, es[k-1][7:0], ec[k-1], eo[k-1]);
        end
      end
      if (k < 4) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        in_valid = 1'b1;
        model(8, longint'(a8), longint'(b8), cin8, es[k], ec[k], eo[k]);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ov8 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end got out_valid=%b want 0", ov8);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({sum_r8, ov8} !== {8'h46, 1'b1}) begin
      n_bad++;
      $display("FAIL arst_pre got %h/%b want 46/1", sum_r8, ov8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sum_r8, cout_r8, ovf_r8, ov8} !== '0) begin
      n_bad++;
      $display("FAIL arst_clear got %h/%b/%b/%b want 00/0/0/0", sum_r8, cout_r8, ovf_r8, ov8);
    end
    a8 = 8'h55; b8 = 8'h0A; cin8 = 1;
    #1;
    n_cmp++;
    if ({sum8, cout8} !== {8'h60, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_comb got %h/%b want 60/0", sum8, cout8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random16();
    longint ps = 0, es;
    bit     pc = 0, po = 0, pv = 0, ec, eo;
    longint hs = 0;
    bit     hc = 0, ho = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (pv) begin hs = ps; hc = pc; ho = po; end
      n_cmp++;
      if ({sum_r16, cout_r16, ovf_r16, ov16} !== {hs[15:0], hc, ho, pv}) begin
        n_bad++;
        $display("FAIL rand_reg[%0d] got %h/%b/%b/%b want %h/%b/%b/%b", n,
                 sum_r16, cout_r16, ovf_r16, ov16, hs[15:0], hc, ho, pv);
      end
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      model(16, longint'(a16), longint'(b16), cin16, es, ec, eo);
      #1;
      n_cmp++;
      if ({cout16, sum16} !== {ec, es[15:0]}) begin
        n_bad++;
        $display("FAIL rand_comb[%0d] a=%h b=%h cin=%b got %b/%h want %b/%h", n,
                 a16, b16, cin16, cout16, sum16, ec, es[15:0]);
      end
      ps = es; pc = ec; po = eo; pv = in_valid;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_comb_sweep();
    test_reset();
    test_single_w1();
    test_w8_boundaries();
    test_back_to_back();
    test_async_reset();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Ripple-carry adder computing a + b + cin; default configuration is a 1-bit full adder.
- Two output views:
  - Combinational sum/cout, valid whenever inputs are stable, with no dependence on the clock.
  - Registered copy with a valid flag and signed-overflow flag, for timing-closed consumers downstream in the datapath.
- Used as a leaf arithmetic cell and as a building block for wider adders.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered view.
- rst_n  input  1  asynchronous active-low reset; clears registered view only.
- a  input  WIDTH  operand A (unsigned or two's-complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- in_valid  input  1  qualifies a/b/cin for capture into the registered view.
- sum  output  WIDTH  combinational sum, (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry out of the MSB.
- sum_r  output  WIDTH  registered sum.
- cout_r  output  1  registered carry out.
- ovf_r  output  1  registered signed overflow.
- out_valid  output  1  high for one cycle per captured operation.

Behaviour:
- Structure is a bit-level ripple chain of full-adder cells:
  - Cell i computes s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]).
  - c[0] = cin; cout = c[WIDTH].
- Combinational outputs sum/cout:
  - Purely combinational, zero latency.
  - Unaffected by clk, rst_n or in_valid; correct even if clk is never toggled and rst_n is undriven.
  - {cout, sum} equals a + b + cin exactly, in WIDTH+1 bits.
- Signed overflow = c[WIDTH] ^ c[WIDTH-1].
  - For WIDTH = 1, c[0] is cin, so overflow = cout ^ cin.
- Registered view:
  - On rising clk with in_valid = 1: sum_r <= sum, cout_r <= cout, ovf_r <= overflow, out_valid <= 1. Latency is 1 cycle.
  - On rising clk with in_valid = 0: out_valid <= 0; sum_r/cout_r/ovf_r hold their last values.
  - Back-to-back in_valid produces back-to-back results, one per cycle; there is no stall and no backpressure.
- Reset:
  - rst_n low asynchronously forces sum_r = 0, cout_r = 0, ovf_r = 0, out_valid = 0, regardless of clk.
  - Outputs stay in that state while rst_n is low; an in_valid during reset is dropped.
  - The first capture can occur on the first rising clk after rst_n deasserts.
  - Reset asserted mid-stream discards the pending result; out_valid drops immediately.
- Inputs containing X/Z propagate X on the combinational outputs; no masking logic.
- There are no internal state machines beyond the single pipeline register stage.

Test Plan:
- WIDTH=1, no clock, rst_n undriven, sweep all 8 (a, b, cin) combinations with 10 time-unit holds:
  - sum/cout = 000->0/0, 001->1/0, 010->1/0, 011->0/1, 100->1/0, 101->0/1, 110->0/1, 111->1/1.
- WIDTH=1, clocked, rst_n released, a=1, b=1, cin=1, in_valid=1 for one cycle:
  - Next edge gives sum_r=1, cout_r=1, ovf_r=0, out_valid=1; the following cycle out_valid=0 and sum_r/cout_r hold.
- WIDTH=8:
  - a=0xFF, b=0x01, cin=0: sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0: sum=0x80, cout=0, ovf=1 in the registered view.
- WIDTH=8, a=0x80, b=0x80, cin=1:
  - sum=0x01, cout=1, ovf_r=1.
  - Streaming 4 consecutive in_valid vectors yields 4 consecutive out_valid pulses with matching results.
- Assert rst_n low between clock edges while out_valid=1:
  - All registered outputs go to 0 immediately.
  - Combinational sum/cout continue tracking inputs.
- Randomized, WIDTH=16, 1000 vectors:
  - {cout, sum} == a + b + cin every vector.
  - Registered outputs equal the previous-cycle combinational values when in_valid was high.
